// File: rtl/piezo_tone_bank.sv
// Keypad-to-beep tone generator: one square-wave pitch per digit key, timed beep,
// one-hot tone lines d0..d9 plus the latched digit code for the piezo mux.
module piezo_tone_bank #(
    parameter int BEEP_CYCLES = 100000,
    parameter int TONE_SHIFT  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       busy,
    output logic [3:0] regi,
    output logic       d0,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic       d4,
    output logic       d5,
    output logic       d6,
    output logic       d7,
    output logic       d8,
    output logic       d9
);

    // Handshake: key_valid is a one-cycle strobe with no ready; a digit key is
    // accepted on any cycle it is presented (also mid-beep), codes 10..15 are dropped.

    typedef enum logic {IDLE, BEEP} state_t;

    localparam logic [19:0] BEEP_LOAD = 20'(BEEP_CYCLES - 1);

    state_t      state, state_nx;
    logic [19:0] beep_timer, timer_nx;
    logic [10:0] tone_cnt, cnt_nx;
    logic        phase, phase_nx;
    logic [3:0]  regi_q, regi_nx;
    logic [9:0]  d_q, d_nx;
    logic [10:0] h_key, h_cur;
    logic        accept;

    function automatic logic [10:0] half_period(input logic [3:0] code);
        logic [10:0] base;
        logic [10:0] h;
        case (code)
            4'd0:    base = 11'd1908;
            4'd1:    base = 11'd1701;
            4'd2:    base = 11'd1515;
            4'd3:    base = 11'd1433;
            4'd4:    base = 11'd1276;
            4'd5:    base = 11'd1136;
            4'd6:    base = 11'd1012;
            4'd7:    base = 11'd956;
            4'd8:    base = 11'd852;
            4'd9:    base = 11'd759;
            default: base = 11'd1908;
        endcase
        h = base >> TONE_SHIFT;
        if (h == 11'd0) h = 11'd1;
        return h;
    endfunction

    assign accept = key_valid && (key_code <= 4'd9);
    assign h_key  = half_period(key_code);
    assign h_cur  = half_period(regi_q);

    always_comb begin
        state_nx = state;
        regi_nx  = regi_q;
        timer_nx = beep_timer;
        cnt_nx   = tone_cnt;
        phase_nx = phase;
        if (accept) begin
            // A fresh press wins over timer expiry and restarts the waveform high.
            state_nx = BEEP;
            regi_nx  = key_code;
            timer_nx = BEEP_LOAD;
            cnt_nx   = h_key - 11'd1;
            phase_nx = 1'b1;
        end else if (state == BEEP) begin
            if (beep_timer == 20'd0) begin
                state_nx = IDLE;
                phase_nx = 1'b0;
                cnt_nx   = 11'd0;
            end else begin
                timer_nx = beep_timer - 20'd1;
                if (tone_cnt == 11'd0) begin
                    cnt_nx   = h_cur - 11'd1;
                    phase_nx = ~phase;
                end else begin
                    cnt_nx = tone_cnt - 11'd1;
                end
            end
        end
    end

    // Tone lines are decoded from next-state values so they register alongside it.
    assign d_nx = (state_nx == BEEP && phase_nx) ? (10'b1 << regi_nx) : 10'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            regi_q     <= 4'd0;
            beep_timer <= 20'd0;
            tone_cnt   <= 11'd0;
            phase      <= 1'b0;
            d_q        <= 10'd0;
        end else begin
            state      <= state_nx;
            regi_q     <= regi_nx;
            beep_timer <= timer_nx;
            tone_cnt   <= cnt_nx;
            phase      <= phase_nx;
            d_q        <= d_nx;
        end
    end

    assign busy = (state == BEEP);
    assign regi = regi_q;
    assign d0   = d_q[0];
    assign d1   = d_q[1];
    assign d2   = d_q[2];
    assign d3   = d_q[3];
    assign d4   = d_q[4];
    assign d5   = d_q[5];
    assign d6   = d_q[6];
    assign d7   = d_q[7];
    assign d8   = d_q[8];
    assign d9   = d_q[9];

endmodule

// File: tb/tb_piezo_tone_bank.sv
// Directed bench for piezo_tone_bank: a digit table plus hand-written retrigger,
// expiry-collision, reset and minimum-half-period sequences.
module tb_piezo_tone_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kv1 = 1'b0, kv2 = 1'b0;
    logic [3:0] kc1 = 4'd0, kc2 = 4'd0;
    logic       busy1, busy2;
    logic [3:0] regi1, regi2;
    logic [9:0] dv1, dv2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    piezo_tone_bank #(.BEEP_CYCLES(400), .TONE_SHIFT(4)) dut (
        .clk(clk), .rst(rst), .key_valid(kv1), .key_code(kc1),
        .busy(busy1), .regi(regi1),
        .d0(dv1[0]), .d1(dv1[1]), .d2(dv1[2]), .d3(dv1[3]), .d4(dv1[4]),
        .d5(dv1[5]), .d6(dv1[6]), .d7(dv1[7]), .d8(dv1[8]), .d9(dv1[9])
    );

    piezo_tone_bank #(.BEEP_CYCLES(20), .TONE_SHIFT(11)) dut_s11 (
        .clk(clk), .rst(rst), .key_valid(kv2), .key_code(kc2),
        .busy(busy2), .regi(regi2),
        .d0(dv2[0]), .d1(dv2[1]), .d2(dv2[2]), .d3(dv2[3]), .d4(dv2[4]),
        .d5(dv2[5]), .d6(dv2[6]), .d7(dv2[7]), .d8(dv2[8]), .d9(dv2[9])
    );

    int         sel = 0;
    logic       cur_busy;
    logic [3:0] cur_regi;
    logic [9:0] cur_d;
    assign cur_busy = (sel != 0) ? busy2 : busy1;
    assign cur_regi = (sel != 0) ? regi2 : regi1;
    assign cur_d    = (sel != 0) ? dv2 : dv1;

    typedef struct {
        logic [3:0] code;
        logic       exp_busy;
        logic [3:0] exp_regi;
        int         exp_h;
    } vec_t;

    vec_t vecs[14];

    int run_len[32];
    int n_runs;
    int busy_len;
    int others_bad;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive a one-cycle strobe; returns sampled just after the accepting edge.
    task automatic press(input int which, input logic [3:0] code);
        @(negedge clk);
        if (which != 0) begin kv2 = 1'b1; kc2 = code; end
        else begin kv1 = 1'b1; kc1 = code; end
        @(posedge clk);
        #1;
        kv1 = 1'b0;
        kv2 = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Record run lengths of d[code] and the busy length until busy falls.
    task automatic watch(input int code);
        logic last;
        int idx;
        busy_len   = 0;
        n_runs     = 0;
        others_bad = 0;
        idx        = -1;
        last       = 1'b0;
        for (int c = 0; c < 3000 && cur_busy; c++) begin
            busy_len++;
            if ((cur_d & ~(10'b1 << code)) != 10'd0) others_bad++;
            if (idx < 0 || cur_d[code] != last) begin
                n_runs++;
                if (idx < 31) idx++;
                run_len[idx] = 1;
            end else begin
                run_len[idx]++;
            end
            last = cur_d[code];
            @(posedge clk);
            #1;
        end
        check("busy_fell_in_time", int'(cur_busy), 0);
        check("d_zero_after_beep", int'(cur_d), 0);
        check("other_lines_quiet", others_bad, 0);
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{4'd0,  1'b1, 4'd0, 119};
        vecs[1]  = '{4'd12, 1'b0, 4'd0, 0};
        vecs[2]  = '{4'd1,  1'b1, 4'd1, 106};
        vecs[3]  = '{4'd15, 1'b0, 4'd1, 0};
        vecs[4]  = '{4'd2,  1'b1, 4'd2, 94};
        vecs[5]  = '{4'd3,  1'b1, 4'd3, 89};
        vecs[6]  = '{4'd4,  1'b1, 4'd4, 79};
        vecs[7]  = '{4'd5,  1'b1, 4'd5, 71};
        vecs[8]  = '{4'd6,  1'b1, 4'd6, 63};
        vecs[9]  = '{4'd7,  1'b1, 4'd7, 59};
        vecs[10] = '{4'd8,  1'b1, 4'd8, 53};
        vecs[11] = '{4'd9,  1'b1, 4'd9, 47};
        vecs[12] = '{4'd10, 1'b0, 4'd9, 0};
        vecs[13] = '{4'd11, 1'b0, 4'd9, 0};

        // Reset state
        step(3);
        check("reset_busy", int'(busy1), 0);
        check("reset_regi", int'(regi1), 0);
        check("reset_d", int'(dv1), 0);
        check("reset_busy_s11", int'(busy2), 0);
        check("reset_d_s11", int'(dv2), 0);
        @(negedge clk);
        rst = 1'b0;
        step(2);

        // Digit table
        for (int i = 0; i < 14; i++) begin
            press(0, vecs[i].code);
            check($sformatf("v%0d_busy", i), int'(busy1), int'(vecs[i].exp_busy));
            check($sformatf("v%0d_regi", i), int'(regi1), int'(vecs[i].exp_regi));
            if (vecs[i].exp_busy) begin
                check($sformatf("v%0d_d_first", i), int'(dv1), int'(10'b1 << vecs[i].code));
                watch(int'(vecs[i].code));
                check($sformatf("v%0d_high1", i), run_len[0], vecs[i].exp_h);
                check($sformatf("v%0d_low1", i), run_len[1], vecs[i].exp_h);
                check($sformatf("v%0d_busy_len", i), busy_len, 400);
                if (vecs[i].code == 4'd0) begin
                    check("key0_nruns", n_runs, 4);
                    check("key0_high2", run_len[2], 119);
                    check("key0_tail_low", run_len[3], 43);
                end
            end else begin
                check($sformatf("v%0d_d_idle", i), int'(dv1), 0);
                step(1);
                check($sformatf("v%0d_busy_next", i), int'(busy1), 0);
            end
            step(2);
        end

        // Retrigger: key 3, then key 9 fifty cycles later
        press(0, 4'd3);
        cnt = 1;
        for (int i = 0; i < 49; i++) begin
            step(1);
            if (busy1) cnt++;
        end
        press(0, 4'd9);
        check("retrig_first_busy", cnt, 50);
        check("retrig_d3_low", int'(dv1[3]), 0);
        check("retrig_d9_high", int'(dv1[9]), 1);
        check("retrig_regi", int'(regi1), 9);
        watch(9);
        check("retrig_h9", run_len[0], 47);
        check("retrig_busy_len", busy_len, 400);
        step(2);

        // Retrigger on the expiry cycle of the previous beep
        press(0, 4'd7);
        step(399);
        check("expiry_still_busy", int'(busy1), 1);
        press(0, 4'd2);
        check("collide_busy", int'(busy1), 1);
        check("collide_regi", int'(regi1), 2);
        check("collide_d2", int'(dv1), int'(10'b1 << 2));
        watch(2);
        check("collide_h2", run_len[0], 94);
        check("collide_busy_len", busy_len, 400);
        step(2);

        // Reset 100 cycles into a key-5 beep
        press(0, 4'd5);
        step(99);
        check("pre_reset_busy", int'(busy1), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", int'(busy1), 0);
        check("midrst_regi", int'(regi1), 0);
        check("midrst_d", int'(dv1), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        press(0, 4'd5);
        check("post_rst_regi", int'(regi1), 5);
        watch(5);
        check("post_rst_h5", run_len[0], 71);
        check("post_rst_busy_len", busy_len, 400);

        // Half-period forced to 1: d9 toggles every cycle
        sel = 1;
        press(1, 4'd9);
        check("s11_regi", int'(regi2), 9);
        check("s11_d_first", int'(dv2), int'(10'b1 << 9));
        watch(9);
        check("s11_busy_len", busy_len, 20);
        check("s11_nruns", n_runs, 20);
        cnt = 0;
        for (int i = 0; i < 20; i++) if (run_len[i] != 1) cnt++;
        check("s11_unit_runs", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/piezo_tone_bank.md
# piezo_tone_bank

Upstream stage of the piezo output path. It turns a keypad press into a timed square-wave beep, one pitch per digit key. It drives the ten per-digit tone lines d0..d9 and the 4-bit digit code regi into the 10:1 piezo multiplexer. Only the tone line of the active digit ever toggles; every other line is held low, so the mux output is silent whenever no beep is in progress.

## Interface
Parameters:
- BEEP_CYCLES, 100000, beep length in clk cycles (100 ms at 1 MHz); legal range 1..2^20-1.
- TONE_SHIFT, 0, right-shift applied to every tone half-period; nonzero only to shorten simulation.

Ports:
- clk, input, 1, single system clock (1 MHz nominal).
- rst, input, 1, synchronous active-high reset.
- key_valid, input, 1, one-cycle strobe: key_code holds a new key press.
- key_code, input, 4, pressed key; digit keys are 0..9, and codes 10..15 are ignored.
- busy, output, 1, high while a beep is sounding.
- regi, output, 4, latched digit code, fed to the mux select.
- d0..d9, output, 1 each, tone square waves; only d[regi] toggles, and only while busy is high.

## Operation
Half-period table, in clk cycles at 1 MHz, before the shift (digit: note → cycles):
- 0: C4 → 1908
- 1: D4 → 1701
- 2: E4 → 1515
- 3: F4 → 1433
- 4: G4 → 1276
- 5: A4 → 1136
- 6: B4 → 1012
- 7: C5 → 956
- 8: D5 → 852
- 9: E5 → 759

Tone half-period:
- H = table[code] >> TONE_SHIFT, computed with 11-bit unsigned arithmetic.
- If the result is 0, it is forced to 1.

State machine has two states, IDLE and BEEP:
- IDLE, when key_valid=1 and key_code≤9:
  - latch the code into regi;
  - load the beep timer with BEEP_CYCLES-1;
  - load the tone counter with H-1;
  - set phase=1;
  - go to BEEP.
- IDLE, when key_valid=1 and key_code≥10: nothing changes.
- BEEP, every cycle:
  - The beep timer decrements.
  - The tone counter decrements. When it reaches 0 it reloads H-1 and phase toggles.
- BEEP, on the cycle the beep timer equals 0: next state is IDLE and phase clears.
- BEEP, retrigger: key_valid=1 with a code ≤9 restarts the beep exactly as from IDLE. The new code is taken, both counters reload, and phase=1. Retrigger has priority over timer expiry in the same cycle.
- BEEP, key_valid with a code ≥10: ignored; the beep continues unchanged.

Outputs:
- d[i] = phase AND (state==BEEP) AND (regi==i); all outputs are registered.
- regi keeps the last accepted code after the beep ends.
- busy = (state==BEEP).

Reset:
- Values after reset: state=IDLE, regi=0, phase=0, busy=0, all d=0, and both counters 0.
- Reset has priority over key_valid in the same cycle.
- Reset during a beep silences all outputs at the next edge.

## Timing
- Acceptance: key_valid is sampled at edge k.
  - From edge k+1: busy=1, regi=code, d[code]=1.
- Tone: high for H cycles, then low for H cycles, repeating. The first toggle to 0 happens at edge k+1+H.
- Duration: busy is high for exactly BEEP_CYCLES cycles.
  - At edge k+1+BEEP_CYCLES: busy=0 and all d=0. The tone may be cut mid-half-period.
- Retrigger at edge j: the waveform restarts high at j+1 and the beep lasts BEEP_CYCLES from there.
- Latency from key_valid to audible output is 1 cycle.
- There is no handshake back to the key source; strobes must not be stalled.

## Test plan
- Basic beep (TONE_SHIFT=4, BEEP_CYCLES=400), key_code=0 accepted at edge k:
  - regi=0, with H=119;
  - d0 is high 119 cycles, low 119, high 119, then low 43;
  - busy falls at edge k+401;
  - d1..d9 stay 0 throughout.
- Ignored code: key_valid with key_code=12 while IDLE → busy, regi and all d are unchanged (busy=0, regi stays at its previous value).
- Retrigger (TONE_SHIFT=4, BEEP_CYCLES=400): key 3 pressed, then key 9 pressed 50 cycles later:
  - d3 drops to 0 at the retrigger edge+1;
  - d9 goes high with H=47;
  - busy lasts 400 cycles after the second press (450 in total).
- Simultaneous events: a retrigger arrives on the same cycle the beep timer expires → busy stays 1 and the new beep runs the full BEEP_CYCLES.
- Reset mid-beep: rst=1 asserted 100 cycles into a key-5 beep → at the next edge busy=0, regi=0, all d=0; a subsequent key 5 beeps normally.
- TONE_SHIFT=11 with key 9 → H is forced to 1, so d9 toggles every cycle for BEEP_CYCLES cycles.
